lcd_timing_gen: RTL and testbench

Parametrised LCD video timing generator and pixel-source mux. It is the successor of the fixed 800x480 MTL controller. It generates sync, data-enable and frame markers for any panel geometry, with selectable sync polarity. It issues pixel read requests ahead of time to cover a configurable memory read latency, and chooses between streamed pixel data, a solid colour, colour bars or black. It sits between the SDRAM read FIFO and the LCD pins.

---
 rtl/lcd_timing_gen.sv | 146 ++++++++++++++
 tb/tb_lcd_timing_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parametrised LCD sync/DE/frame-marker generator with pixel pre-fetch
// requests and a stream/solid/colour-bar/black source mux.
module lcd_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 210,
    parameter int   H_SYNC   = 1,
    parameter int   H_BP     = 45,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 22,
    parameter int   V_SYNC   = 1,
    parameter int   V_BP     = 22,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   RD_LAT   = 1
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [1:0]  iMODE,
    input  logic [23:0] iSOLID_RGB,
    input  logic [31:0] iPIX_DATA,
    input  logic        iPIX_VALID,
    input  logic        iCLR_UNDERFLOW,
    output logic        oPIX_REQ,
    output logic        oHD,
    output logic        oVD,
    output logic        oDE,
    output logic [7:0]  oLCD_R,
    output logic [7:0]  oLCD_G,
    output logic [7:0]  oLCD_B,
    output logic        oNewFrame,
    output logic        oEndFrame,
    output logic [15:0] oFRAME_CNT,
    output logic        oUNDERFLOW
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int XW = $clog2(H_TOTAL + 5);
    localparam int YW = $clog2(V_TOTAL + 1);
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int BW = $clog2(BAR_W + 1);
    localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] HS_END  = XW'(H_SYNC);
    localparam logic [XW-1:0] HA_BEG  = XW'(H_SYNC + H_BP);
    localparam logic [XW-1:0] HA_END  = XW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [XW-1:0] HA_LAST = XW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [XW-1:0] LAT     = XW'(RD_LAT);
    localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] VS_END  = YW'(V_SYNC);
    localparam logic [YW-1:0] VA_BEG  = YW'(V_SYNC + V_BP);
    localparam logic [YW-1:0] VA_END  = YW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [YW-1:0] VA_LAST = YW'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic [1:0] M_STREAM = 2'd0;
    localparam logic [1:0] M_SOLID  = 2'd1;
    localparam logic [1:0] M_BARS   = 2'd2;
    localparam logic [1:0] M_BLACK  = 2'd3;

    logic [XW-1:0] x_q, x_d, xr;
    logic [YW-1:0] y_q, y_d;
    logic [1:0]    mode_q, mode_d;
    logic [23:0]   solid_q, solid_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic          hd_q, hd_d, vd_q, vd_d, de_q, de_d, nf_q, nf_d, ef_q, ef_d, uf_q, uf_d;
    logic [23:0]   rgb_q, rgb_d, bar_rgb, src_rgb;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          h_end, v_end, at_origin, h_act, v_act, act, starve;
    logic          pix_unused;

    assign pix_unused = ^iPIX_DATA[31:24];

    always_comb begin
        h_end     = x_q == H_LAST;
        v_end     = y_q == V_LAST;
        at_origin = x_q == '0 && y_q == '0;
        h_act     = x_q >= HA_BEG && x_q < HA_END;
        v_act     = y_q >= VA_BEG && y_q < VA_END;
        act       = h_act && v_act;
        // Request runs RD_LAT clocks ahead of the pixel, never leaving the current line.
        xr        = x_q + LAT;
        oPIX_REQ  = mode_q == M_STREAM && v_act && xr >= HA_BEG && xr < HA_END;
        x_d       = h_end ? '0 : x_q + 1'b1;
        y_d       = !h_end ? y_q : v_end ? '0 : y_q + 1'b1;
        mode_d    = at_origin ? iMODE : mode_q;
        solid_d   = at_origin ? iSOLID_RGB : solid_q;
        bcnt_d    = (!h_act || bcnt_q == BAR_LAST) ? '0 : bcnt_q + 1'b1;
        bidx_d    = !h_act ? '0 : (bcnt_q == BAR_LAST && bidx_q != 3'd7) ? bidx_q + 1'b1 : bidx_q;
        // Bar order white,yellow,cyan,green,magenta,red,blue,black maps straight onto index bits.
        bar_rgb   = {{8{~bidx_q[1]}}, {8{~bidx_q[2]}}, {8{~bidx_q[0]}}};
        starve    = act && mode_q == M_STREAM && !iPIX_VALID;
        src_rgb   = mode_q == M_STREAM ? (iPIX_VALID ? iPIX_DATA[23:0] : '0) :
                    mode_q == M_SOLID  ? solid_q :
                    mode_q == M_BARS   ? bar_rgb : '0;
        rgb_d     = act ? src_rgb : '0;
        hd_d      = x_q < HS_END ? HS_POL : ~HS_POL;
        vd_d      = y_q < VS_END ? VS_POL : ~VS_POL;
        de_d      = act;
        nf_d      = at_origin;
        ef_d      = x_q == HA_LAST && y_q == VA_LAST;
        uf_d      = starve || (uf_q && !iCLR_UNDERFLOW);
        fcnt_d    = (h_end && v_end) ? fcnt_q + 1'b1 : fcnt_q;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= M_BLACK;
            solid_q <= '0;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            hd_q    <= ~HS_POL;
            vd_q    <= ~VS_POL;
            de_q    <= 1'b0;
            nf_q    <= 1'b0;
            ef_q    <= 1'b0;
            uf_q    <= 1'b0;
            rgb_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            hd_q    <= hd_d;
            vd_q    <= vd_d;
            de_q    <= de_d;
            nf_q    <= nf_d;
            ef_q    <= ef_d;
            uf_q    <= uf_d;
            rgb_q   <= rgb_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign oHD        = hd_q;
    assign oVD        = vd_q;
    assign oDE        = de_q;
    assign {oLCD_R, oLCD_G, oLCD_B} = rgb_q;
    assign oNewFrame  = nf_q;
    assign oEndFrame  = ef_q;
    assign oFRAME_CNT = fcnt_q;
    assign oUNDERFLOW = uf_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: small-panel bench; per-frame expected pixels are queued and popped
// by a monitor on every oDE cycle, with a latency-RD_LAT memory model feeding the stream.
module tb_lcd_timing_gen;
    localparam int HA = 20, HFP = 3, HS = 2, HBP = 3;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 2;
    localparam int LAT = 3;
    localparam int HT = HS + HBP + HA + HFP;
    localparam int VT = VS + VBP + VA + VFP;
    localparam int NPIX = HA * VA;
    localparam int BARW = HA / 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  mode = 2'd3;
    logic [23:0] solid = '0;
    logic [31:0] pix_data = '0;
    logic        pix_valid = 1'b0, clr_a = 1'b0, clr_b = 1'b0, clr;
    logic        req, hd, vd, de, nf, ef, uf;
    logic [7:0]  r, g, b;
    logic [15:0] fcnt;

    assign clr = clr_a | clr_b;
    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(LAT)
    ) dut (
        .iCLK(clk), .iRST_n(rst_n), .iMODE(mode), .iSOLID_RGB(solid),
        .iPIX_DATA(pix_data), .iPIX_VALID(pix_valid), .iCLR_UNDERFLOW(clr),
        .oPIX_REQ(req), .oHD(hd), .oVD(vd), .oDE(de),
        .oLCD_R(r), .oLCD_G(g), .oLCD_B(b),
        .oNewFrame(nf), .oEndFrame(ef), .oFRAME_CNT(fcnt), .oUNDERFLOW(uf)
    );

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [23:0] code(int k);
        return {8'(k % HA), 8'(k / HA), 8'hC3};
    endfunction

    function automatic logic [23:0] expect_px(int m, logic [23:0] s, int drop, int k);
        int bi;
        if (m == 0) return (k == drop) ? 24'h000000 : code(k);
        if (m == 1) return s;
        if (m == 3) return 24'h000000;
        bi = (k % HA) / BARW;
        if (bi > 7) bi = 7;
        case (bi)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // frame plan: mode, latched solid colour, dropped request index, clear-with-drop, flag after frame
    int          p_mode [7] = '{0, 0, 0, 2, 1, 3, 3};
    logic [23:0] p_solid[7] = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h123456, 24'h654321, 24'h654321};
    int          p_drop [7] = '{-1, 5, 30, -1, -1, -1, -1};
    bit          p_clr  [7] = '{0, 0, 1, 0, 0, 0, 0};
    bit          p_uf   [7] = '{0, 1, 1, 1, 1, 1, 1};

    logic pipe_v[LAT+1];
    int   pipe_k[LAT+1];
    int   req_k = 0, drop_k = -1;
    bit   clr_same = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= LAT; i++) begin
                pipe_v[i] = 1'b0;
                pipe_k[i] = 0;
            end
            req_k = 0;
            pix_valid = 1'b0;
            clr_b = 1'b0;
        end else begin
            for (int i = LAT; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_k[i] = pipe_k[i-1];
            end
            pipe_v[0] = req;
            pipe_k[0] = req_k;
            if (req) req_k = (req_k + 1) % NPIX;
            pix_data  = {8'hEE, code(pipe_k[LAT])};
            pix_valid = pipe_v[LAT] && pipe_k[LAT] != drop_k;
            clr_b     = pipe_v[LAT] && pipe_k[LAT] == drop_k && clr_same;
        end
    end

    logic [23:0] exp_q[$];
    bit mon_en = 0;

    always @(negedge clk) begin
        if (rst_n && mon_en && de) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: got pixel %0h expected none", {r, g, b});
            end else check("pixel", {8'h00, r, g, b}, {8'h00, exp_q.pop_front()});
        end
    end

    int cyc = 0, n_de = 0, n_hd = 0, n_vd = 0, n_req = 0, n_ef = 0, n_efbad = 0;
    int l_cyc, l_de, l_hd, l_vd, l_req, l_ef, l_efbad;

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (nf) begin
                l_cyc = cyc; l_de = n_de; l_hd = n_hd; l_vd = n_vd;
                l_req = n_req; l_ef = n_ef; l_efbad = n_efbad;
                cyc = 0; n_de = 0; n_hd = 0; n_vd = 0; n_req = 0; n_ef = 0; n_efbad = 0;
            end
            cyc++;
            n_de  += de ? 1 : 0;
            n_hd  += hd ? 0 : 1;
            n_vd  += vd ? 0 : 1;
            n_req += req ? 1 : 0;
            n_ef  += ef ? 1 : 0;
            if (ef && !(de && n_de == NPIX)) n_efbad++;
        end
    end

    initial begin
        int waited;
        bit ok;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_hd", hd, 1);
        check("rst_vd", vd, 1);
        check("rst_de", de, 0);
        check("rst_rgb", {r, g, b}, 0);
        check("rst_nf", nf, 0);
        check("rst_ef", ef, 0);
        check("rst_uf", uf, 0);
        check("rst_fcnt", fcnt, 0);
        check("rst_req", req, 0);
        mode = 2'(p_mode[0]);
        solid = p_solid[0];
        mon_en = 1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 7; f++) begin
            waited = 0;
            ok = 0;
            while (!ok && waited < 2 * HT * VT) begin
                @(negedge clk);
                waited++;
                ok = nf;
            end
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL newframe_timeout: got no oNewFrame in %0d clocks expected one per %0d", waited, HT * VT);
                break;
            end
            if (f == 0) begin
                check("first_nf_latency", waited, 1);
                check("first_hd_active", hd, 0);
                check("first_vd_active", vd, 0);
            end
            #1;
            check("frame_cnt", fcnt, f);
            if (f > 0) begin
                check("frame_period", l_cyc, HT * VT);
                check("de_per_frame", l_de, NPIX);
                check("hsync_clocks", l_hd, HS * VT);
                check("vsync_clocks", l_vd, VS * HT);
                check("req_per_frame", l_req, p_mode[f-1] == 0 ? NPIX : 0);
                check("endframe_pulses", l_ef, 1);
                check("endframe_misaligned", l_efbad, 0);
                check("underflow_flag", uf, p_uf[f-1]);
            end
            if (f == 6) break;
            for (int k = 0; k < NPIX; k++)
                exp_q.push_back(expect_px(p_mode[f], p_solid[f], p_drop[f], k));
            drop_k = p_drop[f];
            clr_same = p_clr[f];
            if (f == 2) begin
                clr_a = 1'b1;
                @(negedge clk);
                clr_a = 1'b0;
                #1;
                check("underflow_cleared", uf, 0);
            end
            repeat (60) @(negedge clk);
            mode = 2'(p_mode[f+1]);
            solid = p_solid[f+1];
        end
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
